// File: rtl/fifo_rd_adapter.sv
// fifo_rd_adapter: turns a one-cycle-latency fifo read port into a
// valid/ready stream through a 2-entry skid buffer with a transfer counter.
module fifo_rd_adapter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    logic [DATA_WIDTH-1:0] slot_q [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;
    logic                  inflight;
    logic                  pop;
    logic [2:0]            committed;
    logic [1:0]            occ_next;

    // Slots already owed: buffered plus in flight, minus the one leaving now.
    // A read is only issued when that leaves a free slot for its capture.
    always_comb begin
        pop        = m_valid & m_ready;
        committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        occ_next   = occ + {1'b0, inflight} - {1'b0, pop};
        fifo_rd_en = rst_n & enable & ~fifo_empty & (committed < 3'd2);
        m_valid    = (occ != 2'd0);
        m_data     = slot_q[rd_ptr];
        busy       = m_valid | inflight;
    end

    // Occupancy, pointers, in-flight flag and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            inflight   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            xfer_count <= '0;
        end else begin
            occ      <= occ_next;
            inflight <= fifo_rd_en;
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr     <= ~rd_ptr;
                xfer_count <= xfer_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Capture the word popped on the previous edge into the tail slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
        end else if (inflight) begin
            slot_q[wr_ptr] <= fifo_data;
        end
    end

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// tb_fifo_rd_adapter: directed and random stimulus against a queue-based
// model of the upstream fifo and the adapter's output stream.
module tb_fifo_rd_adapter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       m_ready;

    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        busy;
    logic [15:0] xfer_count;

    logic       rd_en4;
    logic       m_valid4;
    logic [7:0] m_data4;
    logic       busy4;
    logic [3:0] xfer4;

    int checks = 0;
    int passed = 0;

    logic [7:0] src[$];
    logic [7:0] mq[$];
    logic       pend_v;
    logic [7:0] pend_d;
    int         exp_xfer;
    int         edge_i;
    int         first_valid;
    int         last_valid;
    int         delivered;
    int         pops;
    logic       rd_s;
    logic       acc_s;

    fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .busy(busy), .xfer_count(xfer_count)
    );

    fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .busy(busy4), .xfer_count(xfer4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One clock: compare at negedge, advance model/upstream fifo at posedge.
    task automatic tick();
        logic ev, eb, erd;
        int   owed;
        @(negedge clk);
        ev   = rst_n && (mq.size() != 0);
        eb   = ev || pend_v;
        owed = mq.size() + int'(pend_v) - int'(ev && m_ready);
        erd  = rst_n && enable && (src.size() != 0) && (owed < 2);
        chk("rd_en", fifo_rd_en, erd);
        chk("m_valid", m_valid, ev);
        if (ev) chk("m_data", m_data, mq[0]);
        chk("busy", busy, eb);
        chk("xfer_count", xfer_count, exp_xfer[15:0]);
        chk("rd_en_w4", rd_en4, erd);
        chk("m_valid_w4", m_valid4, ev);
        if (ev) chk("m_data_w4", m_data4, mq[0]);
        chk("busy_w4", busy4, eb);
        chk("xfer_w4", xfer4, exp_xfer[3:0]);
        rd_s  = fifo_rd_en;
        acc_s = ev && m_ready;
        if (ev && first_valid < 0) first_valid = edge_i;
        if (acc_s) begin
            delivered++;
            last_valid = edge_i;
        end
        @(posedge clk);
        edge_i++;
        if (rst_n) begin
            if (acc_s && mq.size() != 0) begin
                void'(mq.pop_front());
                exp_xfer++;
            end
            if (pend_v) mq.push_back(pend_d);
            pend_v = rd_s && (src.size() != 0);
            if (pend_v) begin
                pend_d = src.pop_front();
                pops++;
            end
        end
        #1;
        fifo_data  = pend_d;
        fifo_empty = (src.size() == 0);
    endtask

    task automatic load(input int n, input int base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) src.push_back(8'($urandom_range(0, 255)));
            else src.push_back(8'(base + i));
        end
        fifo_empty = (src.size() == 0);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (((enable && src.size() != 0) || pend_v || mq.size() != 0)
               && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, mq.size() + int'(pend_v), 0);
        chk({name, "_idle"}, busy, 1'b0);
    endtask

    task automatic mark();
        edge_i      = 0;
        first_valid = -1;
        last_valid  = -1;
        delivered   = 0;
        pops        = 0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        mq.delete();
        pend_v   = 1'b0;
        exp_xfer = 0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_xfer", xfer_count, 16'h0);
        chk("rst_xfer_w4", xfer4, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = 8'h00;
        pend_v     = 1'b0;
        pend_d     = 8'h00;
        exp_xfer   = 0;
        rd_s       = 1'b0;
        acc_s      = 1'b0;
        mark();
        tick();
        tick();
        rst_n = 1'b1;

        // Idle with an empty fifo.
        enable  = 1'b1;
        m_ready = 1'b1;
        repeat (5) tick();
        chk("idle_rd_en", fifo_rd_en, 1'b0);
        chk("idle_m_valid", m_valid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_xfer", xfer_count, 16'd0);

        // Streaming 0..15 at full rate.
        load(16, 0, 1'b0);
        mark();
        drain("stream", 100);
        chk("stream_first_edge", first_valid, 2);
        chk("stream_span", last_valid - first_valid, 15);
        chk("stream_count", delivered, 16);
        chk("stream_xfer", xfer_count, 16'd16);
        chk("stream_xfer_w4", xfer4, 4'h0);

        // Back-pressure with a full fifo.
        enable  = 1'b0;
        m_ready = 1'b0;
        load(16, 0, 1'b0);
        mark();
        enable = 1'b1;
        repeat (8) tick();
        chk("bp_pops", pops, 2);
        chk("bp_rd_en", fifo_rd_en, 1'b0);
        chk("bp_m_valid", m_valid, 1'b1);
        chk("bp_m_data", m_data, 8'h00);
        m_ready = 1'b1;
        mark();
        drain("bp", 100);
        chk("bp_first", first_valid, 0);
        chk("bp_span", last_valid - first_valid, 15);
        chk("bp_count", delivered, 16);

        // Random downstream stalls over 200 random words.
        load(200, 0, 1'b1);
        mark();
        for (int n = 0; n < 3000; n++) begin
            if (src.size() == 0 && !pend_v && mq.size() == 0) break;
            m_ready = 1'($urandom_range(0, 1));
            tick();
        end
        m_ready = 1'b1;
        drain("rand", 20);
        chk("rand_count", delivered, 200);

        // Enable dropped after three pops.
        enable = 1'b0;
        load(8, 8'h64, 1'b0);
        mark();
        enable = 1'b1;
        for (int n = 0; n < 20 && pops < 3; n++) tick();
        enable = 1'b0;
        drain("endrop", 20);
        repeat (4) tick();
        chk("endrop_pops", pops, 3);
        chk("endrop_delivered", delivered, 3);
        chk("endrop_left", src.size(), 5);

        // Reset with two words buffered, then counter wrap at 4 bits.
        m_ready = 1'b0;
        enable  = 1'b1;
        for (int n = 0; n < 10 && mq.size() < 2; n++) tick();
        chk("pre_rst_m_data", m_data, 8'h67);
        pulse_reset();
        enable  = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();
        chk("post_rst_m_valid", m_valid, 1'b0);
        load(12, 8'hC0, 1'b0);
        enable = 1'b1;
        mark();
        drain("wrap15", 100);
        chk("wrap15_count", delivered, 15);
        chk("wrap15_xfer_w4", xfer4, 4'hF);
        load(1, 8'hEE, 1'b0);
        drain("wrap16", 20);
        chk("wrap_xfer_w4", xfer4, 4'h0);
        chk("wrap_xfer", xfer_count, 16'd16);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
